// File: rtl/dmem_responder_pkg.sv
// LC-3b shared types for the data-memory responder: word/mask types,
// responder FSM states and the byte-masked merge used on writes.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [1:0]  lc3b_mem_wmask;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_t;

  // Merge new data into an old word; mask bit0 selects [7:0], bit1 selects [15:8].
  function automatic lc3b_word apply_wmask(input lc3b_word old_word,
                                           input lc3b_word new_word,
                                           input lc3b_mem_wmask mask);
    lc3b_word merged;
    merged = old_word;
    if (mask[0]) begin
      merged[7:0] = new_word[7:0];
    end
    if (mask[1]) begin
      merged[15:8] = new_word[15:8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_responder_array.sv
// Word-organised storage for the data-memory responder: synchronous
// byte-masked write, combinational read. Contents survive reset.
module dmem_array
  import lc3b_types::*;
#(
  parameter int ADDR_BITS = 10
) (
  input  logic                 clk,
  input  logic                 we_i,
  input  logic [ADDR_BITS-1:0] idx_i,
  input  lc3b_mem_wmask        wmask_i,
  input  lc3b_word             wdata_i,
  output lc3b_word             rdata_o
);

  localparam int DEPTH = 1 << ADDR_BITS;

  lc3b_word mem_q [DEPTH];

  // Byte-masked write of the addressed word on a commit.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[idx_i] <= apply_wmask(mem_q[idx_i], wdata_i, wmask_i);
    end
  end

  assign rdata_o = mem_q[idx_i];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: target of the MEM-stage mem_read/mem_write
// interface with WAIT_CYCLES wait states and a one-cycle mem_resp pulse.
// Optional build macro DMEM_PROTOCOL_CHECK_EN adds a sticky proto_err output
// flagging read+write requests and requests that change while waiting.
module dmem_responder
  import lc3b_types::*;
#(
  parameter int ADDR_BITS   = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          mem_read,
  input  logic          mem_write,
  input  lc3b_mem_wmask mem_byte_enable,
  input  lc3b_word      mem_address,
  input  lc3b_word      mem_wdata,
  output logic          mem_resp,
  output lc3b_word      mem_rdata
`ifdef DMEM_PROTOCOL_CHECK_EN
  ,
  output logic          proto_err
`endif
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

  dmem_state_t   state_q, state_d;
  logic [3:0]    cnt_q, cnt_d;
  lc3b_word      addr_q, addr_d;
  lc3b_word      wdata_q, wdata_d;
  lc3b_mem_wmask be_q, be_d;
  logic          wr_q, wr_d;
  logic          resp_q, resp_d;
  lc3b_word      rdata_q, rdata_d;

  logic          req_s;
  logic          commit_s;
  lc3b_word      cm_addr_s;
  lc3b_word      cm_wdata_s;
  lc3b_mem_wmask cm_be_s;
  logic          cm_wr_s;
  lc3b_word      arr_rdata_s;
  logic          unused_addr_s;

  assign req_s = mem_read | mem_write;

  // Next state, request latching and commit selection. With zero wait
  // states the commit edge is the accept edge, so live inputs are used.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    wr_d       = wr_q;
    commit_s   = 1'b0;
    cm_addr_s  = addr_q;
    cm_wdata_s = wdata_q;
    cm_be_s    = be_q;
    cm_wr_s    = wr_q;
    case (state_q)
      IDLE: begin
        if (req_s) begin
          addr_d  = mem_address;
          wdata_d = mem_wdata;
          be_d    = mem_byte_enable;
          wr_d    = mem_write;
          cnt_d   = WAIT_LOAD;
          if (WAIT_CYCLES == 0) begin
            state_d    = RESP;
            commit_s   = 1'b1;
            cm_addr_s  = mem_address;
            cm_wdata_s = mem_wdata;
            cm_be_s    = mem_byte_enable;
            cm_wr_s    = mem_write;
          end else begin
            state_d = WAIT;
          end
        end else begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d  = RESP;
          commit_s = 1'b1;
        end else begin
          state_d = WAIT;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    resp_d = (state_d == RESP);
    if (commit_s && !cm_wr_s) begin
      rdata_d = arr_rdata_s;
    end else begin
      rdata_d = rdata_q;
    end
  end

  assign unused_addr_s = ^cm_addr_s;

  dmem_array #(
    .ADDR_BITS(ADDR_BITS)
  ) u_array (
    .clk     (clk),
    .we_i    (commit_s & cm_wr_s & reset),
    .idx_i   (cm_addr_s[ADDR_BITS:1]),
    .wmask_i (cm_be_s),
    .wdata_i (cm_wdata_s),
    .rdata_o (arr_rdata_s)
  );

  // FSM, counter, request latches and registered response outputs.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      be_q    <= 2'b00;
      wr_q    <= 1'b0;
      resp_q  <= 1'b0;
      rdata_q <= 16'h0000;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      wr_q    <= wr_d;
      resp_q  <= resp_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_resp  = resp_q;
  assign mem_rdata = rdata_q;

`ifdef DMEM_PROTOCOL_CHECK_EN
  logic viol_s;
  logic perr_q;

  // Detect a read+write request in IDLE or a dropped/changed request in WAIT.
  always_comb begin
    viol_s = 1'b0;
    if (state_q == IDLE) begin
      viol_s = mem_read & mem_write;
    end else if (state_q == WAIT) begin
      viol_s = !req_s || (mem_address != addr_q) || (mem_wdata != wdata_q) ||
               (mem_byte_enable != be_q);
    end else begin
      viol_s = 1'b0;
    end
  end

  // Sticky protocol-error flag, cleared only by reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perr_q <= 1'b0;
    end else begin
      perr_q <= perr_q | viol_s;
    end
  end

  assign proto_err = perr_q;

`ifndef SYNTHESIS
  // Report each protocol violation in simulation.
  always_ff @(posedge clk) begin
    if (reset && viol_s) begin
      $error("dmem_responder: protocol violation in state %s", state_q.name());
    end
  end
`endif
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: a WAIT_CYCLES=2 instance for
// latency, byte masks, aliasing and reset abort, and a WAIT_CYCLES=0
// instance for back-to-back throughput.
module tb_dmem_responder;
  import lc3b_types::*;

  localparam int WAITA = 2;

  logic        clk;
  logic        reset;
  logic        mem_read, mem_write;
  logic [1:0]  mem_be;
  logic [15:0] mem_addr, mem_wd;
  logic        resp;
  logic [15:0] rdata;
  logic        r0, w0;
  logic [1:0]  be0;
  logic [15:0] a0, d0;
  logic        resp0;
  logic [15:0] rdata0;

  int vectors = 0;
  int miscompares = 0;
  logic [15:0] model_mem [1024];
  logic [15:0] exp_rd = 16'h0000;
  logic [15:0] sb  [$];
  logic [15:0] sb0 [$];

  dmem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(WAITA)) dut (
    .clk(clk), .reset(reset), .mem_read(mem_read), .mem_write(mem_write),
    .mem_byte_enable(mem_be), .mem_address(mem_addr), .mem_wdata(mem_wd),
    .mem_resp(resp), .mem_rdata(rdata)
  );

  dmem_responder #(.ADDR_BITS(10), .WAIT_CYCLES(0)) dut0 (
    .clk(clk), .reset(reset), .mem_read(r0), .mem_write(w0),
    .mem_byte_enable(be0), .mem_address(a0), .mem_wdata(d0),
    .mem_resp(resp0), .mem_rdata(rdata0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full access on the WAITA instance, starting and ending in IDLE.
  task automatic access(input logic rd, input logic wr, input logic [15:0] a,
                        input logic [15:0] d, input logic [1:0] be, input string tag);
    bit got;
    int lat;
    logic [15:0] e;
    logic [9:0] idx;
    idx = a[10:1];
    if (wr) begin
      if (be[0]) model_mem[idx][7:0] = d[7:0];
      if (be[1]) model_mem[idx][15:8] = d[15:8];
    end else begin
      exp_rd = model_mem[idx];
    end
    sb.push_back(exp_rd);
    mem_read = rd; mem_write = wr; mem_addr = a; mem_wd = d; mem_be = be;
    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      tick();
      if (resp) begin
        got = 1'b1;
        lat = k;
      end
    end
    chk({tag, "_resp"}, 32'(got), 32'd1);
    chk({tag, "_lat"}, lat, WAITA + 1);
    mem_read = 1'b0; mem_write = 1'b0;
    e = sb.pop_front();
    if (got) chk({tag, "_rdata"}, rdata, e);
    tick();
    chk({tag, "_pulse"}, 32'(resp), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    reset = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; mem_be = 2'b00; mem_addr = 16'h0; mem_wd = 16'h0;
    r0 = 1'b0; w0 = 1'b0; be0 = 2'b00; a0 = 16'h0; d0 = 16'h0;
    tick();
    tick();
    chk("rst_resp", 32'(resp), 32'd0);
    chk("rst_rdata", rdata, 16'h0000);
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    reset = 1'b1;
    tick();

    // Zero wait states: write then reads with the request held continuously.
    w0 = 1'b1; a0 = 16'h0040; d0 = 16'h6A6A; be0 = 2'b11;
    tick();
    chk("b0_wresp", 32'(resp0), 32'd1);
    chk("b0_wrdata", rdata0, 16'h0000);
    w0 = 1'b0;
    tick();
    chk("b0_wpulse", 32'(resp0), 32'd0);
    for (int i = 0; i < 4; i++) sb0.push_back(16'h6A6A);
    r0 = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk("b2b_resp", 32'(resp0), 32'(k % 2));
      if (resp0 && sb0.size() > 0) chk("b2b_rdata", rdata0, sb0.pop_front());
    end
    r0 = 1'b0;
    tick();
    chk("b2b_sb", sb0.size(), 0);

    // Two wait states: word/byte writes, aliasing, masked-off writes, read+write.
    access(1'b0, 1'b1, 16'h0010, 16'hBEEF, 2'b11, "w_beef");
    access(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b11, "r_beef");
    access(1'b0, 1'b1, 16'h0011, 16'h12AB, 2'b10, "w_hibyte");
    access(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b11, "r_12ef");
    access(1'b0, 1'b1, 16'h0802, 16'h5555, 2'b11, "w_alias");
    access(1'b1, 1'b0, 16'h0002, 16'h0000, 2'b11, "r_alias");
    access(1'b0, 1'b1, 16'h0004, 16'h3C3C, 2'b11, "w_3c3c");
    access(1'b0, 1'b1, 16'h0004, 16'h7777, 2'b00, "w_be00");
    access(1'b1, 1'b0, 16'h0004, 16'h0000, 2'b11, "r_be00");
    access(1'b1, 1'b1, 16'h0006, 16'h9999, 2'b11, "rw_both");
    access(1'b1, 1'b0, 16'h0006, 16'h0000, 2'b01, "r_both");
    access(1'b0, 1'b1, 16'h0010, 16'h00CD, 2'b01, "w_lobyte");
    access(1'b1, 1'b0, 16'h0010, 16'h0000, 2'b11, "r_12cd");
    access(1'b0, 1'b1, 16'h0020, 16'h1111, 2'b11, "w_1111");
    access(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b11, "r_1111");

    // Reset in the WAIT of a write: aborted, no response, old data kept.
    mem_write = 1'b1; mem_addr = 16'h0020; mem_wd = 16'hAAAA; mem_be = 2'b11;
    tick();
    reset = 1'b0;
    #1;
    chk("abort_resp", 32'(resp), 32'd0);
    chk("abort_rdata", rdata, 16'h0000);
    chk("abort_state", 32'(dut.state_q), 32'(IDLE));
    exp_rd = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("abort_noresp", 32'(resp), 32'd0);
    end
    mem_write = 1'b0;
    reset = 1'b1;
    tick();
    access(1'b1, 1'b0, 16'h0020, 16'h0000, 2'b11, "r_after_abort");

    chk("sb_empty", sb.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the target end of the memory interface driven by the pipeline's MEM stage, which issues mem_read/mem_write.
- Serves LC-3b word and byte accesses (LDW/STW/LDB/STB) with a configurable number of wait states.
- Uses a single-cycle mem_resp handshake.
- Bench/FPGA stand-in for the data cache; sits beside the EX/MEM and MEM/WB registers.

Parameters:
- ADDR_BITS, 10, log2 of word entries in the array (2^ADDR_BITS x 16 bit).
- WAIT_CYCLES, 2, wait states between request acceptance and response; legal range 0..15.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- mem_read  input  1  read request.
- mem_write  input  1  write request.
- mem_byte_enable  input  2  lc3b_mem_wmask; bit0 = low byte [7:0], bit1 = high byte [15:8].
- mem_address  input  16  lc3b_word byte address.
- mem_wdata  input  16  lc3b_word write data.
- mem_resp  output  1  one-cycle completion pulse.
- mem_rdata  output  16  lc3b_word read data.

Behaviour:
- Reset values (reset==0, immediate): state IDLE, mem_resp=0, mem_rdata=16'h0000, wait counter=0.
- The array is not reset; its contents are preserved across reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If mem_read|mem_write, latch address, wdata, byte_enable and op.
  - Load counter=WAIT_CYCLES.
  - Next state is WAIT, or RESP when WAIT_CYCLES==0.
- WAIT: decrement the counter; when the counter==1 at the edge, go to RESP.
- RESP: mem_resp=1 for exactly this cycle; next state is IDLE unconditionally.
- Latency: request first seen high in IDLE cycle N; mem_resp high in cycle N+WAIT_CYCLES+1.
- Throughput: one access per WAIT_CYCLES+2 cycles.
- Requests present during WAIT or RESP are ignored. The initiator holds its request until mem_resp, then drops it or presents a new one; a new request is accepted in the following IDLE cycle.
- Commit point: the edge that enters RESP.
  - Write: byte-masked update of the array at that edge.
  - Read: mem_rdata is loaded with the full word at that edge.
- mem_rdata holds its value until the next read commit; writes do not change it.
- Word index = latched address[ADDR_BITS:1]. address[0] is ignored. Bits above ADDR_BITS alias (wrap modulo 2^(ADDR_BITS+1) bytes).
- Byte read: the responder returns the full word; the MEM stage selects the byte using address[0].
- Write with byte_enable==2'b00: array unchanged; mem_resp still pulses.
- mem_read and mem_write both high: treated as a write. mem_rdata is not updated.
- Reset asserted mid-operation (WAIT or RESP): access aborted immediately.
  - A write not yet at its commit edge is not performed.
  - No mem_resp is issued.

Optional Feature:
- DMEM_PROTOCOL_CHECK_EN defined:
  - Adds output port proto_err (1 bit, reset 0, sticky until reset).
  - proto_err sets when mem_read&mem_write are seen in IDLE.
  - proto_err also sets when, during WAIT, the request drops or mem_address/mem_wdata/mem_byte_enable differ from the latched values.
  - Simulation additionally emits $error on each violation.
- Undefined: no proto_err port and no checks. Functional behaviour is identical.

Decomposition:
- lc3b_types package: lc3b_word, lc3b_mem_wmask (existing), plus a new enum dmem_state_t {IDLE, WAIT, RESP}.
- Sub-module dmem_array:
  - 2^ADDR_BITS x 16 synchronous-write storage with 2-bit byte-enable write mask.
  - Combinational read by index.
  - No reset.
- dmem_responder holds the FSM, the counter and the latches.

Test Plan:
- WAIT_CYCLES=2: write 16'hBEEF to addr 16'h0010, be=2'b11, request in cycle 0 -> mem_resp high in cycle 3 only; read of 16'h0010 -> mem_rdata=16'hBEEF at its resp.
- Byte write 16'h12AB to addr 16'h0011, be=2'b10 over 16'hBEEF -> later word read of 16'h0010 returns 16'h12EF.
- WAIT_CYCLES=0: back-to-back reads with request held continuously -> mem_resp pulses every 2 cycles; no double response.
- Alias: ADDR_BITS=10, write 16'h5555 to 16'h0802 -> read of 16'h0002 returns 16'h5555.
- Reset pulled low in the WAIT of a write of 16'hAAAA to 16'h0020 (old value 16'h1111) -> no mem_resp, state IDLE, mem_rdata=0; subsequent read returns 16'h1111.
- With DMEM_PROTOCOL_CHECK_EN: mem_read=mem_write=1 in IDLE -> proto_err=1 next cycle, write performed, proto_err stays 1 until reset.
